// File: rtl/nios_system_nios2_gen_0_cpu_debug_cmd_queue.sv
// CPU-clock half of the Nios II debug slave, with a command queue.
// JTAG update strobes are synchronised and edge-detected. Each update-DR
// pushes {ir, sr} into a small FIFO. The OCI drains the FIFO one command
// per cycle, and each drained command becomes a one-cycle take_action or
// take_no_action pulse that is indexed by its IR value.
//
// Handshake: the OCI side is valid/ready. "valid" is the internal
// FIFO-not-empty condition and cmd_ready is the consumer's ready.
// A command transfers on every clk edge where both are high. The
// transfer is reported one cycle later as a dispatch pulse, with
// jdo holding the command data.
module nios_system_nios2_gen_0_cpu_debug_cmd_queue #(
   parameter int SR_WIDTH    = 38,
   parameter int IR_WIDTH    = 2,
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int ACT_BIT     = 34,
   localparam int NCMD       = 2 ** IR_WIDTH,
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [IR_WIDTH-1:0] ir_in,
   input  logic [SR_WIDTH-1:0] sr,
   input  logic                vs_udr,
   input  logic                vs_uir,
   input  logic                cmd_ready,
   input  logic                overflow_clr,
   output logic [SR_WIDTH-1:0] jdo,
   output logic [IR_WIDTH-1:0] ir_latched,
   output logic [NCMD-1:0]     take_action,
   output logic [NCMD-1:0]     take_no_action,
   output logic [LVL_W-1:0]    fifo_level,
   output logic                overflow,
   output logic                st_ready_test_idle
);

   localparam int AW    = LVL_W - 1;
   localparam int CMD_W = IR_WIDTH + SR_WIDTH;

   logic [SYNC_STAGES-1:0] udr_sync;
   logic [SYNC_STAGES-1:0] uir_sync;
   logic                   udr_hist;
   logic                   uir_hist;
   logic [IR_WIDTH-1:0]    ir_sync [SYNC_STAGES];

   logic [CMD_W-1:0]       mem [FIFO_DEPTH];
   logic [LVL_W-1:0]       wr_ptr;
   logic [LVL_W-1:0]       rd_ptr;
   logic [LVL_W-1:0]       level;
   logic [CMD_W-1:0]       head;
   logic [IR_WIDTH-1:0]    ir_d;
   logic                   dispatch;

   logic                   udr_edge;
   logic                   uir_edge;
   logic                   empty;
   logic                   full;
   logic                   pop;
   logic                   push_ok;
   logic                   drop;
   logic [NCMD-1:0]        onehot;

   // Synchronise the strobes and the IR, and keep one history flop per strobe for edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         udr_sync <= '0;
         uir_sync <= '0;
         udr_hist <= 1'b0;
         uir_hist <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) ir_sync[i] <= '0;
      end else begin
         udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
         uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
         udr_hist <= udr_sync[SYNC_STAGES-1];
         uir_hist <= uir_sync[SYNC_STAGES-1];
         ir_sync[0] <= ir_in;
         for (int i = 1; i < SYNC_STAGES; i++) ir_sync[i] <= ir_sync[i-1];
      end
   end

   // Decode edges and the push/pop/drop conditions for this cycle
   always_comb begin
      udr_edge = udr_sync[SYNC_STAGES-1] & ~udr_hist;
      uir_edge = uir_sync[SYNC_STAGES-1] & ~uir_hist;
      level    = wr_ptr - rd_ptr;
      empty    = (level == '0);
      full     = (level == LVL_W'(FIFO_DEPTH));
      pop      = ~empty & cmd_ready;
      // A pop in the same cycle frees a slot, so a full queue still accepts the push
      push_ok  = udr_edge & (~full | pop);
      drop     = udr_edge & full & ~pop;
      head     = mem[rd_ptr[AW-1:0]];
   end

   // Command storage; the contents need no reset because the pointers gate every read
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= {ir_sync[SYNC_STAGES-1], sr};
   end

   // Pointers, dispatch register, IR latch and the sticky overflow flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         jdo        <= '0;
         ir_d       <= '0;
         dispatch   <= 1'b0;
         ir_latched <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            jdo    <= head[SR_WIDTH-1:0];
            ir_d   <= head[CMD_W-1:SR_WIDTH];
         end
         dispatch <= pop;
         if (uir_edge) ir_latched <= ir_sync[SYNC_STAGES-1];
         // A drop in the same cycle as a clear keeps the flag set
         if (drop) overflow <= 1'b1;
         else if (overflow_clr) overflow <= 1'b0;
      end
   end

   // Steer the one-hot IR pulse to the action or no-action vector during a dispatch
   always_comb begin
      onehot         = '0;
      onehot[ir_d]   = 1'b1;
      take_action    = '0;
      take_no_action = '0;
      if (dispatch) begin
         if (jdo[ACT_BIT]) take_action    = onehot;
         else              take_no_action = onehot;
      end
      fifo_level         = level;
      st_ready_test_idle = empty & ~dispatch;
   end

endmodule

// File: tb/tb_nios_system_nios2_gen_0_cpu_debug_cmd_queue.sv
// Bench for the debug command queue. A queue-level reference model fed
// from the bench's own input samples predicts each dispatch. A monitor
// compares each dispatch pulse against the expected queue, and it checks
// the status outputs every cycle.
module tb_nios_system_nios2_gen_0_cpu_debug_cmd_queue;
  localparam int SR_W  = 38;
  localparam int IR_W  = 2;
  localparam int SYNC  = 2;
  localparam int DEPTH = 4;
  localparam int ACT   = 34;
  localparam int NCMD  = 4;
  localparam int LVL_W = 3;
  localparam int CMD_W = IR_W + SR_W;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset_n;
  logic [IR_W-1:0]   ir_in;
  logic [SR_W-1:0]   sr;
  logic              vs_udr, vs_uir, cmd_ready, overflow_clr;
  logic [SR_W-1:0]   jdo;
  logic [IR_W-1:0]   ir_latched;
  logic [NCMD-1:0]   take_action, take_no_action;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow, st_ready_test_idle;

  always #5 clk = ~clk;

  nios_system_nios2_gen_0_cpu_debug_cmd_queue dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ready(cmd_ready),
    .overflow_clr(overflow_clr), .jdo(jdo), .ir_latched(ir_latched),
    .take_action(take_action), .take_no_action(take_no_action),
    .fifo_level(fifo_level), .overflow(overflow),
    .st_ready_test_idle(st_ready_test_idle)
  );

  // ---------------- check bookkeeping ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // The model keeps input samples per clk edge. A command enters the model
  // queue SYNC edges after vs_udr is first seen high. It leaves the queue
  // on any edge where the queue holds something and cmd_ready is high.
  logic [CMD_W-1:0] model_q[$];
  logic [CMD_W-1:0] exp_q[$];
  logic             udr_p [SYNC+2];
  logic             uir_p [SYNC+2];
  logic [IR_W-1:0]  ir_p  [SYNC+2];
  logic             m_disp = 1'b0;
  logic             m_ovf  = 1'b0;
  logic [SR_W-1:0]  m_jdo  = '0;
  logic [IR_W-1:0]  m_irl  = '0;
  logic             m_push, m_uir, m_drop;
  logic [CMD_W-1:0] m_e;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_q.delete();
      exp_q.delete();
      m_disp = 1'b0;
      m_ovf  = 1'b0;
      m_jdo  = '0;
      m_irl  = '0;
      for (int j = 0; j < SYNC + 2; j++) begin
        udr_p[j] = 1'b0;
        uir_p[j] = 1'b0;
        ir_p[j]  = '0;
      end
    end else begin
      for (int j = SYNC + 1; j > 0; j--) begin
        udr_p[j] = udr_p[j-1];
        uir_p[j] = uir_p[j-1];
        ir_p[j]  = ir_p[j-1];
      end
      udr_p[0] = vs_udr;
      uir_p[0] = vs_uir;
      ir_p[0]  = ir_in;
      m_push = udr_p[SYNC] & ~udr_p[SYNC+1];
      m_uir  = uir_p[SYNC] & ~uir_p[SYNC+1];
      m_drop = 1'b0;
      m_disp = (model_q.size() != 0) && cmd_ready;
      if (m_disp) begin
        m_e = model_q.pop_front();
        exp_q.push_back(m_e);
        m_jdo = m_e[SR_W-1:0];
      end
      if (m_push) begin
        if (model_q.size() == DEPTH) m_drop = 1'b1;
        else model_q.push_back({ir_p[SYNC], sr});
      end
      if (m_drop) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
      if (m_uir) m_irl = ir_p[SYNC];
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic             mon_pulse;
  logic [CMD_W-1:0] mon_e;
  logic [NCMD-1:0]  mon_oh;

  always @(negedge clk) begin
    mon_pulse = (take_action != '0) || (take_no_action != '0);
    chk("pulse_present", mon_pulse, m_disp);
    if (mon_pulse) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_pulse: got ta=%b tna=%b expected no pulse", take_action, take_no_action);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_oh = '0;
        mon_oh[mon_e[CMD_W-1:SR_W]] = 1'b1;
        chk("sb_jdo", jdo, mon_e[SR_W-1:0]);
        chk("sb_take_action", take_action, mon_e[ACT] ? mon_oh : '0);
        chk("sb_take_no_action", take_no_action, mon_e[ACT] ? '0 : mon_oh);
      end
    end
    chk("fifo_level", fifo_level, model_q.size());
    chk("overflow", overflow, m_ovf);
    chk("ir_latched", ir_latched, m_irl);
    chk("jdo_hold", jdo, m_jdo);
    chk("idle", st_ready_test_idle, (model_q.size() == 0) && !m_disp);
  end

  // ---------------- driver tasks ----------------
  logic [LVL_W-1:0] lvl_after_push;

  // Holds vs_udr high for three edges (k, k+1, k+2). The push edge is k+2.
  task automatic do_update(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] d,
                           input bit clr_at_push = 1'b0, input bit rdy_at_push = 1'b0);
    @(negedge clk);
    ir_in = ir; sr = d; vs_udr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (clr_at_push) overflow_clr = 1'b1;
    if (rdy_at_push) cmd_ready = 1'b1;
    @(negedge clk);
    lvl_after_push = fifo_level;
    vs_udr = 1'b0; overflow_clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Single update into an empty queue with cmd_ready high. This checks the exact pulse cycle.
  task automatic timed_update(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] d,
                              input logic [NCMD-1:0] exp_ta, input logic [NCMD-1:0] exp_tna);
    @(negedge clk);
    ir_in = ir; sr = d; vs_udr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_pulse_quiet", {take_action, take_no_action}, '0);
    vs_udr = 1'b0;
    @(negedge clk);
    chk("timed_take_action", take_action, exp_ta);
    chk("timed_take_no_action", take_no_action, exp_tna);
    chk("timed_jdo", jdo, d);
    @(negedge clk);
    chk("pulse_one_cycle", {take_action, take_no_action}, '0);
    repeat (2) @(negedge clk);
  endtask

  task automatic uir_update(input logic [IR_W-1:0] ir);
    @(negedge clk);
    ir_in = ir; vs_uir = 1'b1;
    repeat (3) @(negedge clk);
    vs_uir = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [SR_W-1:0] rand_sr();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[SR_W-1:0];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    vs_udr = 1'b0; vs_uir = 1'b0; ir_in = '0; sr = '0;
    cmd_ready = 1'b1; overflow_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_jdo", jdo, 0);
    chk("rst_ir_latched", ir_latched, 0);
    chk("rst_pulses", {take_action, take_no_action}, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_idle", st_ready_test_idle, 1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    timed_update(2'b01, 38'h04_0000_1234, 4'b0010, 4'b0000);
    timed_update(2'b11, 38'h00_0000_5678, 4'b0000, 4'b1000);

    // back-pressure: four queued, then drained on consecutive cycles
    cmd_ready = 1'b0;
    for (int i = 1; i <= 4; i++) do_update(IR_W'($urandom_range(0, 3)), SR_W'(i));
    chk("bp_level", fifo_level, 4);
    chk("bp_overflow", overflow, 0);
    cmd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("bp_jdo", jdo, i);
      chk("bp_pulse", (take_action | take_no_action) != '0, 1);
    end
    @(negedge clk);
    chk("bp_drained", fifo_level, 0);

    // overflow: five pushes into four slots
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) do_update(IR_W'($urandom_range(0, 3)), SR_W'(11 + i));
    chk("ovf_set", overflow, 1);
    chk("ovf_level", fifo_level, 4);
    @(negedge clk); overflow_clr = 1'b1;
    @(negedge clk); overflow_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
    do_update(2'b00, SR_W'(16), 1'b1, 1'b0);
    chk("ovf_clr_vs_drop", overflow, 1);
    cmd_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("ovf_last_kept", jdo, 14);
    overflow_clr = 1'b1;
    @(negedge clk); overflow_clr = 1'b0;

    // full queue with a push and pop on the same edge
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_update(IR_W'($urandom_range(0, 3)), SR_W'(21 + i));
    chk("full_level", fifo_level, 4);
    do_update(2'b10, SR_W'(25), 1'b0, 1'b1);
    chk("full_pushpop_level", lvl_after_push, 4);
    chk("full_pushpop_ovf", overflow, 0);
    repeat (6) @(negedge clk);
    chk("full_last_dispatched", jdo, 25);
    chk("full_drained", fifo_level, 0);

    // update-IR only
    uir_update(2'b10);
    chk("uir_latched", ir_latched, 2'b10);
    chk("uir_level", fifo_level, 0);

    // randomized mix
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) uir_update(IR_W'($urandom_range(0, 3)));
      else begin
        cmd_ready = 1'($urandom_range(0, 1));
        do_update(IR_W'($urandom_range(0, 3)), rand_sr(),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end
    end
    cmd_ready = 1'b1; overflow_clr = 1'b1;
    @(negedge clk); overflow_clr = 1'b0;
    repeat (6) @(negedge clk);
    chk("rand_drained", fifo_level, 0);

    // reset while two entries are queued and a pulse is in progress
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_update(IR_W'(i), SR_W'(31 + i));
    cmd_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("pre_reset_pulse", (take_action | take_no_action) != '0, 1);
    chk("pre_reset_level", fifo_level, 2);
    reset_n = 1'b0;
    #1;
    chk("midrst_level", fifo_level, 0);
    chk("midrst_jdo", jdo, 0);
    chk("midrst_pulses", {take_action, take_no_action}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_level", fifo_level, 0);
    timed_update(2'b00, 38'h3F_FFFF_FFFF, 4'b0001, 4'b0000);

    repeat (4) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
